ucdp_debounce: RTL and testbench
================================

// Module: ucdp_debounce
//
// PURPOSE
//   Debounce/glitch filter for a single already-synchronized level, placed directly downstream of
//   ucdp_sync (d_i driven by ucdp_sync.q_o, same clock domain).
//   Accepts a level change only after it has been stable for a run-time programmable number of cycles.
//   Produces a filtered level plus an optional one-cycle edge pulse for switches, pins and slow status lines.
//
// PARAMETERS
//   cntwidth_p   8     width of debounce counter and thres_i
//   rstval_p     1'b0  reset value of filtered level q_o; must match rstval_p of upstream ucdp_sync
//   edge_type_p  2'h0  edge_o select: 0=none, 1=rising, 2=falling, 3=any
//
// PORTS
//   clk_i     in   1           clock
//   rst_an_i  in   1           reset, asynchronous, active-low
//   d_i       in   1           synchronized input level (from ucdp_sync.q_o)
//   en_i      in   1           filter enable; 0 freezes q_o and aborts filtering
//   thres_i   in   cntwidth_p  required stable cycles minus 1 (quasi-static, sampled live)
//   q_o       out  1           debounced level
//   edge_o    out  1           one-cycle pulse on q_o change, per edge_type_p
//   busy_o    out  1           1 while a candidate change is being qualified
//
// BEHAVIOUR
//   - Reset (rst_an_i=0, async): q_o=rstval_p, edge_o=0, busy_o=0, cnt=0, state=IDLE.
//     All outputs are registered.
//   - FSM has 2 states; busy_o=1 exactly in FILTER:
//     IDLE:   en_i=1 & d_i!=q_o & thres_i==0 -> q_o<=d_i, edge pulse, stay IDLE.
//             en_i=1 & d_i!=q_o & thres_i!=0 -> FILTER, cnt<=1.
//             Else stay IDLE, cnt<=0.
//     FILTER: en_i=0           -> IDLE, cnt<=0, q_o unchanged.
//             d_i==q_o (bounce) -> IDLE, cnt<=0, q_o unchanged, no pulse.
//             cnt>=thres_i     -> q_o<=~q_o, edge pulse, IDLE, cnt<=0.
//             Else cnt<=cnt+1.
//   - Latency: with d_i changed and held, q_o toggles on the (thres_i+1)-th rising edge that samples
//     the new value. thres_i=0 gives a plain 1-cycle register.
//   - cnt never wraps. cnt<=thres_i<=2**cntwidth_p-1 is guaranteed by the >= compare.
//     thres_i=all-ones gives 2**cntwidth_p stable cycles.
//   - thres_i lowered mid-FILTER below cnt: accept on the next edge (>= compare). Raised: filtering continues.
//   - edge_o is registered and high for exactly the cycle in which q_o shows the new value:
//     edge 1: rise only; edge 2: fall only; edge 3: both; edge 0: edge_o tied 0.
//   - en_i=0: no q_o change and no edge_o. Re-enable re-qualifies from cnt=0.
//   - Reset asserted mid-FILTER: immediate return to reset values. No pulse on reset release.
//   - Only one transition can be pending at a time (1-bit input); edge_o pulses never occur back-to-back
//     unless thres_i==0.
//
// TESTING
//   1. Reset with rstval_p=0, d_i=0 -> q_o=0, edge_o=0, busy_o=0 through and after release.
//   2. thres_i=3, d_i 0->1 held -> busy_o for 3 cycles; q_o=1 and edge_o=1 (type 1) on 4th edge; edge_o=0 next cycle.
//   3. thres_i=3, d_i=1 for 2 cycles then back to 0 -> busy_o drops, q_o stays 0, no edge_o; a later 4-cycle high is accepted.
//   4. thres_i=0, d_i toggles every cycle, edge_type_p=3 -> q_o = d_i delayed 1 cycle, edge_o=1 every cycle.
//   5. thres_i=8'hFF, d_i held -> q_o changes after exactly 256 sampled cycles; cnt does not overflow.
//   6. Mid-FILTER (cnt=2, thres_i=5): en_i=0 for one cycle, then rst_an_i pulse on a later attempt
//      -> each aborts; q_o unchanged, busy_o=0, re-qualification takes a full 6 cycles.

Source files
------------

// File: rtl/ucdp_debounce.sv
// Debounce/glitch filter for a single synchronized level: a change is accepted only after
// it has been stable for thres_i+1 cycles; provides filtered level, edge pulse and busy flag.
`timescale 1ns/1ps

module ucdp_debounce #(
    parameter int unsigned cntwidth_p  = 8,
    parameter logic        rstval_p    = 1'b0,
    parameter logic [1:0]  edge_type_p = 2'h0
) (
    input  logic                  clk_i,
    input  logic                  rst_an_i,
    input  logic                  d_i,
    input  logic                  en_i,
    input  logic [cntwidth_p-1:0] thres_i,
    output logic                  q_o,
    output logic                  edge_o,
    output logic                  busy_o
);

    typedef enum logic {
        IDLE_ST   = 1'b0,
        FILTER_ST = 1'b1
    } state_t;

    localparam logic [cntwidth_p-1:0] one_c = cntwidth_p'(1);

    state_t                state_q;
    logic [cntwidth_p-1:0] cnt_q;
    logic                  q_q;
    logic                  edge_q;

    // Whether a change to new_lvl produces an edge_o pulse for the configured edge type.
    function automatic logic edge_sel(input logic new_lvl);
        case (edge_type_p)
            2'h1:    return new_lvl;
            2'h2:    return ~new_lvl;
            2'h3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // NOTE: every register here, including the FSM state, uses non-blocking assignments and is
    // cleared by the asynchronous reset so nothing powers up in an unknown state.
    always_ff @(posedge clk_i or negedge rst_an_i) begin
        if (!rst_an_i) begin
            state_q <= IDLE_ST;
            cnt_q   <= '0;
            q_q     <= rstval_p;
            edge_q  <= 1'b0;
        end else begin
            edge_q <= 1'b0;
            case (state_q)
                IDLE_ST: begin
                    if (en_i && (d_i != q_q)) begin
                        if (thres_i == '0) begin
                            q_q    <= d_i;
                            edge_q <= edge_sel(d_i);
                            cnt_q  <= '0;
                        end else begin
                            state_q <= FILTER_ST;
                            cnt_q   <= one_c;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                FILTER_ST: begin
                    if (!en_i || (d_i == q_q)) begin
                        state_q <= IDLE_ST;
                        cnt_q   <= '0;
                    end else if (cnt_q >= thres_i) begin
                        // >= also accepts at once when thres_i was lowered below cnt_q
                        q_q     <= ~q_q;
                        edge_q  <= edge_sel(~q_q);
                        state_q <= IDLE_ST;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + one_c;
                    end
                end
                default: begin
                    state_q <= IDLE_ST;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign q_o    = q_q;
    assign edge_o = edge_q;
    assign busy_o = (state_q == FILTER_ST);

endmodule

// File: tb/tb_ucdp_debounce.sv
// Self-checking bench for ucdp_debounce: four instances (edge types 0..3) share stimulus and are
// compared every cycle against a stable-run-length reference model.
`timescale 1ns/1ps

module tb_ucdp_debounce;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         d     = 1'b0;
    logic         en    = 1'b0;
    logic [W-1:0] thres = '0;
    logic [3:0]   q_w;
    logic [3:0]   edge_w;
    logic [3:0]   busy_w;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: length of the current run of enabled samples that differ from q.
    int   m_run    = 0;
    logic m_q      = 1'b0;
    logic m_toggle = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ucdp_debounce #(
            .cntwidth_p (W),
            .rstval_p   (1'b0),
            .edge_type_p(2'(g))
        ) u_dut (
            .clk_i   (clk),
            .rst_an_i(rst_n),
            .d_i     (d),
            .en_i    (en),
            .thres_i (thres),
            .q_o     (q_w[g]),
            .edge_o  (edge_w[g]),
            .busy_o  (busy_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic exp_edge(input int t);
        if (!m_toggle) return 1'b0;
        return (t == 3) || (t == 1 && m_q) || (t == 2 && !m_q);
    endfunction

    task automatic model_reset();
        m_run    = 0;
        m_q      = 1'b0;
        m_toggle = 1'b0;
    endtask

    task automatic model_step();
        m_toggle = 1'b0;
        if (!en || d == m_q) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run >= int'(thres) + 1) begin
                m_q      = d;
                m_toggle = 1'b1;
                m_run    = 0;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int t = 0; t < 4; t++) begin
            check($sformatf("%s/q%0d", tag, t), 32'(q_w[t]), 32'(m_q));
            check($sformatf("%s/edge%0d", tag, t), 32'(edge_w[t]), 32'(exp_edge(t)));
            check($sformatf("%s/busy%0d", tag, t), 32'(busy_w[t]), 32'(m_run != 0));
        end
    endtask

    // Called at a negedge: drive inputs, let one rising edge happen, compare at the next negedge.
    task automatic cycle(input string tag, input logic dv, input logic ev, input logic [W-1:0] tv);
        d     = dv;
        en    = ev;
        thres = tv;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        d = 1'b0;
        #1;
        model_reset();
        check_outputs({tag, "/async"});
        @(negedge clk);
        check_outputs({tag, "/held"});
        rst_n = 1'b1;
    endtask

    // Hold d=dv with threshold tv until lane 3 shows dv; returns the cycle count (bounded).
    task automatic measure(input string tag, input logic dv, input logic [W-1:0] tv, output int n);
        n = 0;
        while (q_w[3] !== dv && n < 300) begin
            cycle(tag, dv, 1'b1, tv);
            n++;
        end
    endtask

    initial begin
        int n;

        // Reset with d=0: outputs stay at reset values through and after release.
        @(negedge clk);
        model_reset();
        check_outputs("rst_low");
        rst_n = 1'b1;
        repeat (3) cycle("rst_rel", 1'b0, 1'b1, 8'd3);

        // thres=3, held high: 3 busy cycles, accept on the 4th edge, single pulse.
        repeat (4) cycle("t2", 1'b1, 1'b1, 8'd3);
        check("t2_q_after4", 32'(q_w[1]), 32'd1);
        cycle("t2_after", 1'b1, 1'b1, 8'd3);
        check("t2_edge_cleared", 32'(edge_w[1]), 32'd0);

        // Bounce: short low excursion rejected, then a full 4-cycle low accepted.
        repeat (2) cycle("t3_bounce", 1'b0, 1'b1, 8'd3);
        repeat (3) cycle("t3_back", 1'b1, 1'b1, 8'd3);
        measure("t3_accept", 1'b0, 8'd3, n);
        check("t3_latency", 32'(n), 32'd4);

        // thres=0: plain one-cycle register, edge every cycle for any-edge type.
        for (int i = 0; i < 16; i++) cycle("t4_toggle", logic'(i[0] ^ 1'b1), 1'b1, 8'd0);

        // thres=all-ones: exactly 256 sampled cycles.
        do_reset("t5_rst");
        measure("t5", 1'b1, 8'hFF, n);
        check("t5_latency256", 32'(n), 32'd256);

        // Aborts mid-FILTER: en_i low, then reset pulse; each requires a full 6-cycle requalify.
        do_reset("t6_rst");
        repeat (2) cycle("t6_pre_en", 1'b1, 1'b1, 8'd5);
        cycle("t6_en_off", 1'b1, 1'b0, 8'd5);
        measure("t6_requal_en", 1'b1, 8'd5, n);
        check("t6_latency_en", 32'(n), 32'd6);
        do_reset("t6_rst2");
        repeat (2) cycle("t6_pre_rst", 1'b1, 1'b1, 8'd5);
        do_reset("t6_midrst");
        measure("t6_requal_rst", 1'b1, 8'd5, n);
        check("t6_latency_rst", 32'(n), 32'd6);

        // Lowering thres mid-FILTER below cnt accepts on the next edge.
        repeat (4) cycle("thr_lower_a", 1'b0, 1'b1, 8'd9);
        cycle("thr_lower_b", 1'b0, 1'b1, 8'd1);
        check("thr_lower_q", 32'(q_w[0]), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic dv;
            logic ev;
            logic [W-1:0] tv;
            dv = ($urandom_range(3) == 0) ? ~d : d;
            ev = ($urandom_range(15) != 0);
            tv = ($urandom_range(31) == 0) ? W'($urandom_range(6)) : thres;
            if ($urandom_range(499) == 0) do_reset("rnd_rst");
            else cycle("rnd", dv, ev, tv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end

endmodule
